// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// MemReady exists only when MIPS_MEM_WAIT_EN is defined.
interface mips_multicycle_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
`ifdef MIPS_MEM_WAIT_EN
  logic       MemReady;
`endif
  logic       PCEn;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [2:0] AluCtl;
  logic [1:0] PCSrc;
  logic       ExtOp;
  logic       IllegalOp;
  logic [3:0] State;

`ifdef MIPS_MEM_WAIT_EN
  modport master (
    input  Op, Funct, Zero, MemReady,
    output PCEn, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           AluSrcA, AluSrcB, AluCtl, PCSrc, ExtOp, IllegalOp, State
  );
  modport slave (
    output Op, Funct, Zero, MemReady,
    input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           AluSrcA, AluSrcB, AluCtl, PCSrc, ExtOp, IllegalOp, State
  );
`else
  modport master (
    input  Op, Funct, Zero,
    output PCEn, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           AluSrcA, AluSrcB, AluCtl, PCSrc, ExtOp, IllegalOp, State
  );
  modport slave (
    output Op, Funct, Zero,
    input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           AluSrcA, AluSrcB, AluCtl, PCSrc, ExtOp, IllegalOp, State
  );
`endif
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing a multicycle MIPS datapath (R-type, lw, sw, beq, addi, ori, j).
// Define MIPS_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on MemReady.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  mips_multicycle_ctrl_if.master ctl
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q, state_d;

  logic       mem_rdy;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       pc_write, branch;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       src_a, ext_op, illegal;
  logic [1:0] src_b, pc_src;
  logic [2:0] alu_ctl;

`ifdef MIPS_MEM_WAIT_EN
  assign mem_rdy = ctl.MemReady;
`else
  assign mem_rdy = 1'b1;
`endif

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (ctl.Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    src_a      = 1'b0;
    src_b      = 2'b00;
    alu_ctl    = ALU_ADD;
    pc_src     = 2'b00;
    ext_op     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        src_b    = 2'b01;
        ir_write = mem_rdy;
        pc_write = mem_rdy;
        state_d  = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        src_b  = 2'b11;
        ext_op = 1'b1;
        case (ctl.Op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_BEQ:          state_d = S_BEQ;
          OP_ADDI, OP_ORI: state_d = S_IEXEC;
          OP_J:            state_d = S_JUMP;
          OP_R: begin
            illegal = !funct_ok;
            state_d = funct_ok ? S_EXEC : S_FETCH;
          end
          default:         illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        ext_op  = 1'b1;
        state_d = (ctl.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      // The write strobe repeats on every stalled cycle; memory treats it as idempotent.
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        src_a   = 1'b1;
        alu_ctl = funct_alu;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQ: begin
        src_a   = 1'b1;
        alu_ctl = ALU_SUB;
        pc_src  = 2'b01;
        branch  = 1'b1;
      end
      S_IEXEC: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        alu_ctl = (ctl.Op == OP_ORI) ? ALU_OR : ALU_ADD;
        ext_op  = (ctl.Op != OP_ORI);
        state_d = S_IMMWB;
      end
      S_IMMWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: alu_ctl = 3'b000;
    endcase
  end

  // Reset suppresses every side effect in the cycle it is asserted.
  always_comb begin
    ctl.PCEn      = !Reset && (pc_write || (branch && ctl.Zero));
    ctl.IorD      = !Reset && iord;
    ctl.MemWrite  = !Reset && mem_write;
    ctl.IRWrite   = !Reset && ir_write;
    ctl.RegDst    = !Reset && reg_dst;
    ctl.MemToReg  = !Reset && mem_to_reg;
    ctl.RegWrite  = !Reset && reg_write;
    ctl.AluSrcA   = !Reset && src_a;
    ctl.AluSrcB   = Reset ? 2'b00 : src_b;
    ctl.AluCtl    = Reset ? 3'b000 : alu_ctl;
    ctl.PCSrc     = Reset ? 2'b00 : pc_src;
    ctl.ExtOp     = !Reset && ext_op;
    ctl.IllegalOp = !Reset && illegal;
    ctl.State     = state_q;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction stream against a table-driven reference of the controller.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluctl;
    logic [1:0] pcsrc;
    logic       extop;
    logic       illegal;
  } ctl_t;

  logic CLK = 1'b0;
  logic Reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   path_q[$];

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .ctl   (bus.master)
  );

  always #5 CLK = ~CLK;

  ctl_t obs;
  assign obs = '{bus.PCEn, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst,
                 bus.MemToReg, bus.RegWrite, bus.AluSrcA, bus.AluSrcB,
                 bus.AluCtl, bus.PCSrc, bus.ExtOp, bus.IllegalOp};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic r_funct_ok(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic legal(input logic [5:0] op, input logic [5:0] f);
    case (op)
      6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101, 6'b000010: return 1'b1;
      6'b000000: return r_funct_ok(f);
      default:   return 1'b0;
    endcase
  endfunction

  // State sequence an instruction visits, from the CPI table.
  function automatic void make_path(input logic [5:0] op, input logic [5:0] f);
    path_q = {0, 1};
    if (legal(op, f)) begin
      case (op)
        6'b100011: path_q = {path_q, 2, 3, 4};
        6'b101011: path_q = {path_q, 2, 5};
        6'b000000: path_q = {path_q, 6, 7};
        6'b000100: path_q = {path_q, 8};
        6'b000010: path_q = {path_q, 11};
        default:   path_q = {path_q, 9, 10};
      endcase
    end
  endfunction

  function automatic ctl_t exp_ctl(input int s, input logic [5:0] op, input logic [5:0] f,
                                   input logic zero, input logic mr);
    ctl_t c;
    c = '0;
    c.aluctl = 3'b010;
    case (s)
      0:  begin c.srcb = 2'b01; c.irwrite = mr; c.pcen = mr; end
      1:  begin c.srcb = 2'b11; c.extop = 1'b1; c.illegal = !legal(op, f); end
      2:  begin c.srca = 1'b1; c.srcb = 2'b10; c.extop = 1'b1; end
      3:  c.iord = 1'b1;
      4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      6:  case (f)
            6'b100010: c.aluctl = 3'b110;
            6'b100100: c.aluctl = 3'b000;
            6'b100101: c.aluctl = 3'b001;
            6'b101010: c.aluctl = 3'b111;
            default:   c.aluctl = 3'b010;
          endcase
      7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      8:  begin c.aluctl = 3'b110; c.pcsrc = 2'b01; c.pcen = zero; end
      9:  begin c.srcb = 2'b10; c.extop = (op != 6'b001101);
                c.aluctl = (op == 6'b001101) ? 3'b001 : 3'b010; end
      10: c.regwrite = 1'b1;
      11: begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
      default: c.aluctl = 3'b000;
    endcase
    if (s inside {6, 8, 9}) c.srca = 1'b1;
    return c;
  endfunction

  initial begin
    logic [5:0] op, f;
    logic       mr, abort;
    int         idx, budget, sel;
    logic [5:0] r_functs [5];
    r_functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    Reset     = 1'b1;
    bus.Op    = 6'd0;
    bus.Funct = 6'd0;
    bus.Zero  = 1'b0;
`ifdef MIPS_MEM_WAIT_EN
    bus.MemReady = 1'b1;
`endif
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      bus.Zero = 1'b1;
      #1;
      chk("reset_ctl", 32'(obs), 32'(0));
      if (i == 1) chk("reset_state", 32'(bus.State), 32'd0);
    end

    for (int n = 0; n < 250; n++) begin
      sel = (n < 6) ? n : $urandom_range(0, 9);
      case (sel)
        0: begin op = 6'b100011; f = 6'($urandom); end
        1: begin op = 6'b000000; f = 6'b101010; end
        2: begin op = 6'b000100; f = 6'($urandom); end
        3: begin op = 6'b111111; f = 6'($urandom); end
        4: begin op = 6'b000000; f = 6'b000000; end
        5: begin op = 6'b101011; f = 6'($urandom); end
        6: begin op = 6'b000000; f = r_functs[$urandom_range(0, 4)]; end
        7: begin
             case ($urandom_range(0, 3))
               0: op = 6'b001000;
               1: op = 6'b001101;
               2: op = 6'b000010;
               default: op = 6'b000100;
             endcase
             f = 6'($urandom);
           end
        8: begin op = 6'($urandom); f = 6'($urandom); end
        default: begin op = 6'b000000; f = 6'($urandom); end
      endcase
      make_path(op, f);
      idx = 0;
      budget = 0;
      while (idx < path_q.size()) begin
        @(negedge CLK);
        if (idx == 0) begin
          bus.Op    = op;
          bus.Funct = f;
        end
        bus.Zero = 1'($urandom);
        mr = 1'b1;
`ifdef MIPS_MEM_WAIT_EN
        mr = ($urandom_range(0, 3) != 0);
        bus.MemReady = mr;
`endif
        abort = (n >= 6) && (idx > 0) && ($urandom_range(0, 24) == 0);
        Reset = abort;
        #1;
        chk("state", 32'(bus.State), 32'(path_q[idx]));
        if (abort) chk("abort_ctl", 32'(obs), 32'(0));
        else chk($sformatf("ctl_s%0d_op%b", path_q[idx], op), 32'(obs),
                 32'(exp_ctl(path_q[idx], op, f, bus.Zero, mr)));
        if (abort) break;
        if (!((path_q[idx] inside {0, 3, 5}) && !mr)) idx++;
        budget++;
        if (budget > 60) begin
          chk("cycle_budget", 32'd1, 32'd0);
          break;
        end
      end
    end

    @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk("final_state", 32'(bus.State), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
